// File: rtl/hot_pkg.sv
// Shared types and helpers for the one-hot ring monitor.
// Holds the FSM state encoding, default ring entry position and the vector decoder.
package hot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int DEFAULT_START_POS = 4;
  localparam int MAX_W             = 32;
  localparam int MAX_IDX_W         = 5;

  // Returns {legal, idx}; legal means exactly one bit set and none above start_pos.
  function automatic logic [MAX_IDX_W:0] onehot_to_idx(input logic [MAX_W-1:0] vec,
                                                       input int start_pos);
    logic [MAX_IDX_W-1:0] idx;
    int                   ones;
    logic                 high;
    idx  = '0;
    ones = 0;
    high = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (vec[i]) begin
        ones++;
        idx = MAX_IDX_W'(i);
        if (i > start_pos) high = 1'b1;
      end
    end
    return {(ones == 1) && !high, idx};
  endfunction

endpackage

// File: rtl/hot_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Used for the ring rotation count and the optional error count.
module hot_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hot_monitor.sv
// Checker for the one-hot ring sequencer: decodes the token position, checks ring order, counts rotations.
// Define HOT_MONITOR_ERRCNT_EN to add a saturating err_cnt output.
//
// state | meaning
// IDLE  | no legal token seen since reset/clr
// TRACK | following the ring, expected successor known
// FAULT | last sample was not legal one-hot
module hot_monitor
  import hot_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int START_POS = DEFAULT_START_POS,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         hot_in,
  input  logic                     hot_vld,
  input  logic                     clr,
  output logic [$clog2(WIDTH)-1:0] idx_o,
  output logic                     idx_vld,
  output logic                     err_onehot,
  output logic                     err_seq,
  output logic                     err_sticky,
  output logic [CNT_W-1:0]         wrap_cnt,
  output logic [1:0]               state_o
`ifdef HOT_MONITOR_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]         err_cnt
`endif
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] START_IDX = IDX_W'(START_POS);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   exp_q, exp_d;
  logic [IDX_W-1:0]   pos, succ;
  logic               legal;
  logic [MAX_IDX_W:0] conv;
  logic               unused_idx_hi;
  logic               idx_upd, onehot_d, seq_d, wrap_inc, err_any;

  assign conv          = onehot_to_idx(MAX_W'(hot_in), START_POS);
  assign legal         = conv[MAX_IDX_W];
  assign pos           = conv[IDX_W-1:0];
  assign unused_idx_hi = ^conv[MAX_IDX_W-1:IDX_W];
  assign succ          = (pos == '0) ? START_IDX : pos - IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      exp_q   <= START_IDX;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    if (clr) begin
      state_d = IDLE;
      exp_d   = START_IDX;
    end else if (hot_vld) begin
      if (!legal) begin
        state_d = FAULT;
      end else begin
        state_d = TRACK;
        exp_d   = succ;
      end
    end
  end

  // Only TRACK judges order; IDLE and FAULT (re)acquire on any legal token.
  always_comb begin
    idx_upd  = 1'b0;
    onehot_d = 1'b0;
    seq_d    = 1'b0;
    wrap_inc = 1'b0;
    if (!clr && hot_vld) begin
      if (!legal) begin
        onehot_d = 1'b1;
      end else begin
        idx_upd = 1'b1;
        if (state_q == TRACK) begin
          if (pos != exp_q) seq_d = 1'b1;
          else if (pos == START_IDX) wrap_inc = 1'b1;
        end
      end
    end
  end

  assign err_any = onehot_d | seq_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_o      <= '0;
      idx_vld    <= 1'b0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      idx_vld    <= idx_upd;
      err_onehot <= onehot_d;
      err_seq    <= seq_d;
      if (idx_upd) idx_o <= pos;
      if (clr) err_sticky <= 1'b0;
      else if (err_any) err_sticky <= 1'b1;
    end
  end

  assign state_o = state_q;

  hot_sat_cnt #(.W(CNT_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (wrap_inc),
    .cnt   (wrap_cnt)
  );

`ifdef HOT_MONITOR_ERRCNT_EN
  hot_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (err_any),
    .cnt   (err_cnt)
  );
`endif

endmodule

// File: tb/tb_hot_monitor.sv
// Self-checking bench for hot_monitor: directed ring scenarios plus randomized traffic vs a behavioural model.
// Define HOT_MONITOR_ERRCNT_EN to also exercise err_cnt.
module tb_hot_monitor;

  localparam int WIDTH = 6;
  localparam int START = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] hot_in;
  logic             hot_vld;
  logic             clr;
  logic [2:0]       idx_o;
  logic             idx_vld, err_onehot, err_seq, err_sticky;
  logic [CNT_W-1:0] wrap_cnt;
  logic [1:0]       state_o;
`ifdef HOT_MONITOR_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  hot_monitor #(.WIDTH(WIDTH), .START_POS(START), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .hot_in     (hot_in),
    .hot_vld    (hot_vld),
    .clr        (clr),
    .idx_o      (idx_o),
    .idx_vld    (idx_vld),
    .err_onehot (err_onehot),
    .err_seq    (err_seq),
    .err_sticky (err_sticky),
    .wrap_cnt   (wrap_cnt),
    .state_o    (state_o)
`ifdef HOT_MONITOR_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: plain integers following the ring rules.
  int m_state, m_exp, m_idx, m_prev, m_wrap, m_errcnt;
  bit m_vld, m_oh, m_seq, m_sticky;

  wire [16:0] dut_snap = {idx_o, idx_vld, err_onehot, err_seq, err_sticky, wrap_cnt, state_o};

  function automatic logic [16:0] model_snap();
    return {3'(m_idx), m_vld, m_oh, m_seq, m_sticky, 8'(m_wrap), 2'(m_state)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_exp = START; m_idx = 0; m_prev = -1; m_wrap = 0; m_errcnt = 0;
    m_vld = 0; m_oh = 0; m_seq = 0; m_sticky = 0;
  endtask

  task automatic model_step(input logic [WIDTH-1:0] v, input bit vld, input bit c);
    int  ones, pos;
    bit  legal;
    m_vld = 0; m_oh = 0; m_seq = 0;
    if (c) begin
      m_state = 0; m_exp = START; m_wrap = 0; m_sticky = 0; m_errcnt = 0; m_prev = -1;
      return;
    end
    if (!vld) return;
    ones = $countones(v);
    pos  = 0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) pos = i;
    legal = (ones == 1) && (pos <= START);
    if (!legal) begin
      m_state = 2;
      m_oh    = 1;
    end else begin
      if (m_state == 1 && pos != m_exp) m_seq = 1;
      if (m_state == 1 && pos == m_exp && pos == START && m_prev == 0 && m_wrap < CMAX)
        m_wrap++;
      m_idx   = pos;
      m_vld   = 1;
      m_exp   = (pos == 0) ? START : pos - 1;
      m_state = 1;
      m_prev  = pos;
    end
    if (m_oh || m_seq) begin
      m_sticky = 1;
      if (m_errcnt < CMAX) m_errcnt++;
    end
  endtask

  // One clock: drive, let the edge pass, advance the model; outputs are stable at +1.
  task automatic step(input logic [WIDTH-1:0] v, input bit vld, input bit c);
    hot_in  = v;
    hot_vld = vld;
    clr     = c;
    @(posedge clk);
    #1;
    model_step(v, vld, c);
  endtask

  task automatic test_reset();
    reset = 1'b0; hot_in = '0; hot_vld = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (dut_snap !== 17'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", dut_snap);
    end
    #2 reset = 1'b1;
    step('0, 1'b0, 1'b0);
    tests++;
    if (state_o !== 2'd0) begin
      fails++;
      $display("FAIL reset_state: got %0d expected 0", state_o);
    end
  endtask

  task automatic test_ring();
    int exp_idx[6] = '{4, 3, 2, 1, 0, 4};
    for (int k = 0; k < 6; k++) begin
      step(WIDTH'(1 << exp_idx[k]), 1'b1, 1'b0);
      tests++;
      if (idx_o !== 3'(exp_idx[k]) || idx_vld !== 1'b1 || err_onehot !== 1'b0 || err_seq !== 1'b0 || err_sticky !== 1'b0) begin
        fails++;
        $display("FAIL ring_%0d: idx=%0d vld=%b oh=%b seq=%b sticky=%b expected idx=%0d vld=1 no errors",
                 k, idx_o, idx_vld, err_onehot, err_seq, err_sticky, exp_idx[k]);
      end
    end
    tests++;
    if (wrap_cnt !== 8'd1) begin
      fails++;
      $display("FAIL ring_wrap: got %0d expected 1", wrap_cnt);
    end
  endtask

  task automatic test_onehot_fault();
    step(6'b000110, 1'b1, 1'b0);
    tests++;
    if (err_onehot !== 1'b1 || state_o !== 2'd2 || err_sticky !== 1'b1 || idx_vld !== 1'b0 || idx_o !== 3'd4) begin
      fails++;
      $display("FAIL onehot_fault: oh=%b state=%0d sticky=%b vld=%b idx=%0d expected 1 2 1 0 4",
               err_onehot, state_o, err_sticky, idx_vld, idx_o);
    end
    step(6'b001000, 1'b1, 1'b0);
    tests++;
    if (state_o !== 2'd1 || idx_o !== 3'd3 || err_seq !== 1'b0 || err_onehot !== 1'b0 || idx_vld !== 1'b1) begin
      fails++;
      $display("FAIL fault_recover: state=%0d idx=%0d seq=%b oh=%b vld=%b expected 1 3 0 0 1",
               state_o, idx_o, err_seq, err_onehot, idx_vld);
    end
  endtask

  task automatic test_skip();
    step('0, 1'b0, 1'b1);
    step(6'b010000, 1'b1, 1'b0);
    tests++;
    if (err_seq !== 1'b0 || idx_o !== 3'd4) begin
      fails++;
      $display("FAIL skip_first: seq=%b idx=%0d expected 0 4", err_seq, idx_o);
    end
    step(6'b000100, 1'b1, 1'b0);
    tests++;
    if (err_seq !== 1'b1 || idx_o !== 3'd2 || idx_vld !== 1'b1 || state_o !== 2'd1) begin
      fails++;
      $display("FAIL skip_seq: seq=%b idx=%0d vld=%b state=%0d expected 1 2 1 1", err_seq, idx_o, idx_vld, state_o);
    end
    step(6'b000010, 1'b1, 1'b0);
    tests++;
    if (err_seq !== 1'b0 || err_onehot !== 1'b0 || idx_o !== 3'd1) begin
      fails++;
      $display("FAIL skip_resync: seq=%b oh=%b idx=%0d expected 0 0 1", err_seq, err_onehot, idx_o);
    end
  endtask

  task automatic test_saturate();
    step('0, 1'b0, 1'b1);
    step(6'b010000, 1'b1, 1'b0);
    for (int r = 0; r < 260; r++) begin
      for (int p = START - 1; p >= 0; p--) step(WIDTH'(1 << p), 1'b1, 1'b0);
      step(WIDTH'(1 << START), 1'b1, 1'b0);
      tests++;
      if (dut_snap !== model_snap()) begin
        fails++;
        $display("FAIL sat_rot_%0d: got %h expected %h", r, dut_snap, model_snap());
      end
    end
    tests++;
    if (wrap_cnt !== 8'd255) begin
      fails++;
      $display("FAIL sat_value: got %0d expected 255", wrap_cnt);
    end
    step(6'b001000, 1'b1, 1'b1);
    tests++;
    if (wrap_cnt !== 8'd0 || err_sticky !== 1'b0 || state_o !== 2'd0 || idx_vld !== 1'b0 || idx_o !== 3'd4) begin
      fails++;
      $display("FAIL sat_clr: wrap=%0d sticky=%b state=%0d vld=%b idx=%0d expected 0 0 0 0 4",
               wrap_cnt, err_sticky, state_o, idx_vld, idx_o);
    end
  endtask

  task automatic test_reset_mid();
    step(6'b010000, 1'b1, 1'b0);
    step(6'b001000, 1'b1, 1'b0);
    step(6'b000111, 1'b1, 1'b0);
    #1 reset = 1'b0;
    #1;
    model_reset();
    tests++;
    if (dut_snap !== 17'd0) begin
      fails++;
      $display("FAIL reset_mid: got %h expected 0", dut_snap);
    end
`ifdef HOT_MONITOR_ERRCNT_EN
    tests++;
    if (err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid_errcnt: got %0d expected 0", err_cnt);
    end
`endif
    #1 reset = 1'b1;
    step(6'b100000, 1'b1, 1'b0);
    tests++;
    if (err_onehot !== 1'b1 || state_o !== 2'd2 || idx_vld !== 1'b0) begin
      fails++;
      $display("FAIL bit5_illegal: oh=%b state=%0d vld=%b expected 1 2 0", err_onehot, state_o, idx_vld);
    end
  endtask

  task automatic test_hold();
    step('0, 1'b0, 1'b1);
    step(6'b010000, 1'b1, 1'b0);
    step(6'b001000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(WIDTH'($urandom), 1'b0, 1'b0);
      tests++;
      if (idx_vld !== 1'b0 || err_onehot !== 1'b0 || err_seq !== 1'b0 || state_o !== 2'd1 || idx_o !== 3'd3) begin
        fails++;
        $display("FAIL hold_%0d: vld=%b oh=%b seq=%b state=%0d idx=%0d expected 0 0 0 1 3",
                 k, idx_vld, err_onehot, err_seq, state_o, idx_o);
      end
    end
    step(6'b000100, 1'b1, 1'b0);
    tests++;
    if (idx_o !== 3'd2 || idx_vld !== 1'b1 || err_seq !== 1'b0 || err_sticky !== 1'b0) begin
      fails++;
      $display("FAIL hold_resume: idx=%0d vld=%b seq=%b sticky=%b expected 2 1 0 0", idx_o, idx_vld, err_seq, err_sticky);
    end
  endtask

`ifdef HOT_MONITOR_ERRCNT_EN
  task automatic test_errcnt();
    step('0, 1'b0, 1'b1);
    step(6'b000000, 1'b1, 1'b0);
    step(6'b110000, 1'b1, 1'b0);
    tests++;
    if (err_cnt !== 8'd2) begin
      fails++;
      $display("FAIL errcnt_two: got %0d expected 2", err_cnt);
    end
  endtask
`endif

  task automatic test_random();
    logic [WIDTH-1:0] v;
    bit               vld, c;
    int               kind;
    for (int n = 0; n < 600; n++) begin
      kind = int'($urandom_range(0, 19));
      vld  = 1'b1;
      c    = 1'b0;
      if (kind < 12)       v = WIDTH'(1 << m_exp);
      else if (kind < 15)  v = WIDTH'(1 << $urandom_range(0, START));
      else if (kind < 17)  v = WIDTH'($urandom);
      else if (kind < 19)  begin v = WIDTH'($urandom); vld = 1'b0; end
      else                 begin v = WIDTH'($urandom); c = 1'b1; end
      step(v, vld, c);
      tests++;
      if (dut_snap !== model_snap()) begin
        fails++;
        $display("FAIL random_%0d: in=%b vld=%b clr=%b got %h expected %h", n, v, vld, c, dut_snap, model_snap());
      end
`ifdef HOT_MONITOR_ERRCNT_EN
      tests++;
      if (err_cnt !== 8'(m_errcnt)) begin
        fails++;
        $display("FAIL random_errcnt_%0d: got %0d expected %0d", n, err_cnt, m_errcnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_ring();
    test_onehot_fault();
    test_skip();
    test_saturate();
    test_reset_mid();
    test_hold();
`ifdef HOT_MONITOR_ERRCNT_EN
    test_errcnt();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hot_monitor.md
Name: hot_monitor

Overview:
- Downstream checker for the one-hot ring sequencer: samples the ring's token vector each valid cycle, converts it to a binary position, and verifies it is legal one-hot and follows the ring order.
- Counts completed rotations and flags faults for the control/debug logic that consumes the ring phase.

Parameters:
- WIDTH, 6, width of the sampled token vector.
- START_POS, 4, ring entry position (token loaded here after reset and after wrap); legal positions are START_POS..0; bits above START_POS must be 0.
- CNT_W, 8, width of the rotation counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- hot_in  in  WIDTH  token vector from the ring sequencer.
- hot_vld  in  1  hot_in is valid this cycle.
- clr  in  1  synchronous clear of errors, counter and tracking state.
- idx_o  out  $clog2(WIDTH)  binary position of the last legal token.
- idx_vld  out  1  idx_o updated this cycle (1-cycle pulse).
- err_onehot  out  1  pulse: sampled vector not legal one-hot.
- err_seq  out  1  pulse: legal token but not the expected successor.
- err_sticky  out  1  set by any error, held until clr or reset.
- wrap_cnt  out  CNT_W  completed rotations (position 0 -> START_POS transitions).
- state_o  out  2  current FSM state (IDLE=0, TRACK=1, FAULT=2).

Behaviour:
- Reset (reset=0, async): all outputs 0; FSM=IDLE; expected position register = START_POS.
- All outputs registered; 1-cycle latency from a valid sample to idx_vld/err_* pulses.
- Legal vector: exactly one bit set at position p with p <= START_POS. Zero-hot, multi-hot, or any bit above START_POS is illegal.
- Successor rule: exp(p) = p-1 for p>0; exp(0) = START_POS.
- The ring shifts toward bit 0 and re-enters at START_POS.

FSM (evaluated only when hot_vld=1; hot_vld=0 holds all state, pulses 0):
- IDLE:
  - Legal -> TRACK; idx_o=p; idx_vld=1; expected=exp(p); no err_seq on the first sample.
  - Illegal -> FAULT; err_onehot=1.
- TRACK:
  - Legal and p==expected -> stay; idx_o=p; idx_vld=1; expected=exp(p). If p==START_POS and the previous position was 0, wrap_cnt+1.
  - Legal and p!=expected -> err_seq=1; idx_o=p; idx_vld=1; resynchronise expected=exp(p); stay TRACK; no wrap increment.
  - Illegal -> FAULT; err_onehot=1; idx_o holds.
- FAULT:
  - Legal -> TRACK via the IDLE rules (no err_seq).
  - Illegal -> err_onehot=1 each cycle.

Error and counter rules:
- err_sticky = OR of all err pulses, latched.
- wrap_cnt saturates at 2^CNT_W-1 (no wrap-around).

clr:
- Overrides the sample in the same cycle: FSM=IDLE, expected=START_POS, wrap_cnt=0, err_sticky=0, pulses 0; idx_o holds.
- clr during FAULT returns to IDLE.

Reset mid-operation: immediate return to reset values regardless of state or hot_vld.

Optional Feature:
- Macro HOT_MONITOR_ERRCNT_EN.
- Defined: adds output err_cnt [CNT_W-1:0], incremented on every err_onehot or err_seq pulse (at most +1 per cycle), saturating, cleared by clr and reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package hot_pkg:
  - state typedef (IDLE/TRACK/FAULT, 2 bits).
  - Default START_POS constant.
  - Function onehot_to_idx returning {legal, idx} for a vector.
- One natural sub-module, hot_sat_cnt (parameterised saturating counter with inc/clr), used for wrap_cnt and err_cnt.

Test Plan:
- Reset release, then legal ring 10000,01000,00100,00010,00001,10000 with hot_vld=1 -> idx_o 4,3,2,1,0,4; err_* never set; wrap_cnt=1 after the final sample.
- 00110 in TRACK -> err_onehot pulse; state_o=2; err_sticky=1; next 01000 -> state_o=1, idx_o=3, no err_seq.
- 10000 then 00100 (skip) -> err_seq pulse; idx_o=2; next 00010 accepted with no error.
- 255+ full rotations with CNT_W=8 -> wrap_cnt saturates at 255; clr -> wrap_cnt=0, err_sticky=0, state_o=0.
- Assert reset mid-rotation between clock edges -> all outputs 0 immediately; 100000 (bit 5) after release -> err_onehot.
- hot_vld=0 for 3 cycles mid-ring with hot_in toggling garbage -> no pulses, state unchanged; resumes at the expected position. With HOT_MONITOR_ERRCNT_EN defined, two faults -> err_cnt=2.
